execute_stage: RTL
==================

# execute_stage

Execute stage of the RISC-V lab pipeline: combines operand A, operand B and immediate, computes the ALU result or effective address, and hands it to the memory-access stage. Result goes out on an address stream; operand B goes out unchanged on a data stream as store data. Control word travels alongside in a single registered output slot with valid/ready backpressure.

## Interface
- `XLEN`, default 32: operand and result width.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `ctrl_data_i`  input  17  control word: [6:0] opcode, [9:7] funct3, [16:10] funct7.
- `axis_s_opa_tvalid` / `axis_s_opa_tready` / `axis_s_opa_tdata`  in/out/in  1/1/XLEN  operand A (rs1).
- `axis_s_opb_tvalid` / `axis_s_opb_tready` / `axis_s_opb_tdata`  in/out/in  1/1/XLEN  operand B (rs2).
- `axis_s_imm_tvalid` / `axis_s_imm_tready` / `axis_s_imm_tdata`  in/out/in  1/1/XLEN  sign-extended immediate.
- `axis_m_addr_tvalid` / `axis_m_addr_tready` / `axis_m_addr_tdata`  out/in/out  1/1/XLEN  ALU result / address.
- `axis_m_data_tvalid` / `axis_m_data_tready` / `axis_m_data_tdata`  out/in/out  1/1/XLEN  store data (registered operand B).
- `ctrl_data_o`  output  17  control word registered with the result.

## Operation
- Accept: all three s-tready equal `in_rdy = (state==IDLE) && (!out_valid || out_fire)`; a beat is taken only when `in_rdy` and all three s-tvalid are high. s-tready never depends on s-tvalid.
- `out_fire = out_valid && axis_m_addr_tready && axis_m_data_tready`; both m-tvalid are the same `out_valid` signal; tdata/ctrl_data_o hold stable while valid and not fired.
- Result by opcode: LOAD 0000011 and STORE 0100011 -> A+imm; LUI 0110111 -> imm; OP 0110011 -> A op B; OP-IMM 0010011 -> A op imm; any other opcode -> 0 (beat still passes).
- funct3: 000 ADD/SUB, 001 SLL, 010 SLT (signed), 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND. funct7[5] (ctrl bit 15) selects SUB for OP only, SRA/SRAI for both OP and OP-IMM.
- Shift amount = low 5 bits of second operand; arithmetic modulo 2^XLEN, no overflow flag; SLT/SLTU yield 0 or 1.
- Data stream always carries operand B, regardless of opcode.

## Timing
- Reset: out_valid 0, both m-tdata 0, ctrl_data_o 0, state IDLE; s-tready 1 from the first cycle after reset release.
- Latency: accepted beat appears at outputs the next cycle; throughput one beat per cycle when downstream is ready (accept and fire in the same cycle allowed).
- Output slot full and downstream not ready: s-tready 0, slot holds.
- Reset asserted mid-transfer or mid-shift: slot and in-flight beat discarded, FSM to IDLE immediately.
- FSM (serial shift only): IDLE -> SHIFT on accepted shift with shamt>0, counter=shamt; SHIFT shifts one bit per cycle, decrements; counter==1 -> IDLE with out_valid=1. shamt==0 -> no SHIFT state, 1-cycle latency.

## Configuration
- `EXEC_SERIAL_SHIFT_EN` defined: SLL/SRL/SRA(+I) use the serial shifter; latency 1+shamt cycles, s-tready 0 during SHIFT.
- Undefined: single-cycle barrel shifter, FSM stays in IDLE, all ops 1-cycle latency.

## Structure
- Package `exec_pkg`: opcode constants, funct3 codes, ctrl field offsets (OPCODE, FUNCT3, FUNCT7 ranges), ALU operation enum.
- Sub-module `exec_alu`: combinational ALU (op select, operands -> result); top holds handshake, output slot and serial-shift FSM.

## Test plan
- OP ADD A=5, B=7, funct7=0 -> next cycle addr=12, data=7, valid=1; SUB (funct7=0100000) -> addr=0xFFFFFFFE.
- STORE A=0x10, imm=0x4, B=0xDEADBEEF -> addr=0x14, data=0xDEADBEEF, ctrl_data_o[6:0]=0100011.
- SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0; OP-IMM SRAI A=0x80000000, imm=0x404 -> 0xF8000000.
- Backpressure: m-tready low 3 cycles with slot full -> s-tready 0, outputs stable; release -> beat fires, next accepted same cycle.
- With EXEC_SERIAL_SHIFT_EN: SLL A=1, B=31 -> s-tready 0 for 31 cycles, result 0x80000000 at cycle 32; shamt 0 -> 1 cycle.
- rst low during SHIFT with out_valid pending -> all outputs 0 immediately, s-tready 1 after release.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: control-word layout, opcode and
// funct3 encodings, ALU operation set and the control-word decoder.
package exec_pkg;

  localparam int CTRL_W         = 17;
  localparam int OPCODE_LSB     = 0;
  localparam int OPCODE_MSB     = 6;
  localparam int FUNCT3_LSB     = 7;
  localparam int FUNCT3_MSB     = 9;
  localparam int FUNCT7_LSB     = 10;
  localparam int FUNCT7_MSB     = 16;
  localparam int FUNCT7_ALT_BIT = 15;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_ZERO
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic    b_is_imm;
  } dec_t;

  // funct7[5] means SUB only for register-register ops; it always means SRA.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt,
                                       input logic sub_ok);
    alu_op_e r;
    r = ALU_ADD;
    case (f3)
      F3_ADD:  r = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      F3_SLL:  r = ALU_SLL;
      F3_SLT:  r = ALU_SLT;
      F3_SLTU: r = ALU_SLTU;
      F3_XOR:  r = ALU_XOR;
      F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   r = ALU_OR;
      F3_AND:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic dec_t decode(input logic [CTRL_W-1:0] ctrl);
    dec_t       d;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       alt;
    opc = ctrl[OPCODE_MSB:OPCODE_LSB];
    f3  = ctrl[FUNCT3_MSB:FUNCT3_LSB];
    alt = ctrl[FUNCT7_ALT_BIT];
    d.op       = ALU_ZERO;
    d.b_is_imm = 1'b0;
    case (opc)
      OPC_LOAD, OPC_STORE: begin
        d.op       = ALU_ADD;
        d.b_is_imm = 1'b1;
      end
      OPC_LUI: begin
        d.op       = ALU_PASS_B;
        d.b_is_imm = 1'b1;
      end
      OPC_OP: d.op = f3_to_op(f3, alt, 1'b1);
      OPC_OP_IMM: begin
        d.op       = f3_to_op(f3, alt, 1'b0);
        d.b_is_imm = 1'b1;
      end
      default: d.op = ALU_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU of the execute stage; shift amount is the low 5 bits of b.
module exec_alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e           op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << shamt;
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $signed(a) >>> shamt;
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand join, ALU, single registered output slot.
// Build option EXEC_SERIAL_SHIFT_EN replaces the barrel shifter with a 1-bit/cycle shifter.
//
// state    | meaning
// ST_IDLE  | accepting beats whenever the output slot is free or draining
// ST_SHIFT | serial shift in progress, inputs stalled
module execute_stage
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_data_i,
  input  logic              axis_s_opa_tvalid,
  output logic              axis_s_opa_tready,
  input  logic [XLEN-1:0]   axis_s_opa_tdata,
  input  logic              axis_s_opb_tvalid,
  output logic              axis_s_opb_tready,
  input  logic [XLEN-1:0]   axis_s_opb_tdata,
  input  logic              axis_s_imm_tvalid,
  output logic              axis_s_imm_tready,
  input  logic [XLEN-1:0]   axis_s_imm_tdata,
  output logic              axis_m_addr_tvalid,
  input  logic              axis_m_addr_tready,
  output logic [XLEN-1:0]   axis_m_addr_tdata,
  output logic              axis_m_data_tvalid,
  input  logic              axis_m_data_tready,
  output logic [XLEN-1:0]   axis_m_data_tdata,
  output logic [CTRL_W-1:0] ctrl_data_o
);

  logic [0:0]      state;
  logic            out_valid;
  logic            out_fire;
  logic            in_rdy;
  logic            accept;
  dec_t            dec;
  logic [XLEN-1:0] opnd_b;
  logic [XLEN-1:0] alu_result;

  assign out_fire = out_valid && axis_m_addr_tready && axis_m_data_tready;
  assign in_rdy   = (state == ST_IDLE) && (!out_valid || out_fire);
  assign accept   = in_rdy && axis_s_opa_tvalid && axis_s_opb_tvalid && axis_s_imm_tvalid;

  assign axis_s_opa_tready  = in_rdy;
  assign axis_s_opb_tready  = in_rdy;
  assign axis_s_imm_tready  = in_rdy;
  assign axis_m_addr_tvalid = out_valid;
  assign axis_m_data_tvalid = out_valid;

  assign dec    = decode(ctrl_data_i);
  assign opnd_b = dec.b_is_imm ? axis_s_imm_tdata : axis_s_opb_tdata;

  exec_alu #(.XLEN(XLEN)) u_alu (
    .op     (dec.op),
    .a      (axis_s_opa_tdata),
    .b      (opnd_b),
    .result (alu_result)
  );

`ifdef EXEC_SERIAL_SHIFT_EN
  logic [4:0]        sh_cnt;
  logic [XLEN-1:0]   sh_val;
  logic [XLEN-1:0]   sh_next;
  logic [XLEN-1:0]   sh_data;
  logic [CTRL_W-1:0] sh_ctrl;
  alu_op_e           sh_op;
  logic              start_shift;

  // A zero shift amount takes the normal single-cycle path.
  assign start_shift = (dec.op inside {ALU_SLL, ALU_SRL, ALU_SRA}) && (opnd_b[4:0] != 5'd0);

  always_comb begin
    sh_next = {1'b0, sh_val[XLEN-1:1]};
    if (sh_op == ALU_SLL)
      sh_next = {sh_val[XLEN-2:0], 1'b0};
    else if (sh_op == ALU_SRA)
      sh_next = {sh_val[XLEN-1], sh_val[XLEN-1:1]};
  end
`else
  assign state = ST_IDLE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid         <= 1'b0;
      axis_m_addr_tdata <= '0;
      axis_m_data_tdata <= '0;
      ctrl_data_o       <= '0;
`ifdef EXEC_SERIAL_SHIFT_EN
      state   <= ST_IDLE;
      sh_cnt  <= '0;
      sh_val  <= '0;
      sh_data <= '0;
      sh_ctrl <= '0;
      sh_op   <= ALU_SLL;
`endif
    end
`ifdef EXEC_SERIAL_SHIFT_EN
    else if (state == ST_SHIFT) begin
      // The last step waits for a free slot before publishing the result.
      if (sh_cnt == 5'd1) begin
        if (!out_valid || out_fire) begin
          state             <= ST_IDLE;
          out_valid         <= 1'b1;
          axis_m_addr_tdata <= sh_next;
          axis_m_data_tdata <= sh_data;
          ctrl_data_o       <= sh_ctrl;
          sh_val            <= sh_next;
          sh_cnt            <= '0;
        end
      end else begin
        sh_val <= sh_next;
        sh_cnt <= sh_cnt - 5'd1;
        if (out_fire)
          out_valid <= 1'b0;
      end
    end
`endif
    else if (accept) begin
`ifdef EXEC_SERIAL_SHIFT_EN
      if (start_shift) begin
        state     <= ST_SHIFT;
        sh_cnt    <= opnd_b[4:0];
        sh_val    <= axis_s_opa_tdata;
        sh_op     <= dec.op;
        sh_data   <= axis_s_opb_tdata;
        sh_ctrl   <= ctrl_data_i;
        out_valid <= 1'b0;
      end else
`endif
      begin
        out_valid         <= 1'b1;
        axis_m_addr_tdata <= alu_result;
        axis_m_data_tdata <= axis_s_opb_tdata;
        ctrl_data_o       <= ctrl_data_i;
      end
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule
